// File: rtl/dispatch_unit.sv
// rtl/dispatch_unit.sv - in-order IFQ dispatch into INT/FP/MEM issue slots
// Optional perf counters are compiled in with `define DISPATCH_PERF_EN.
module dispatch_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     flush,
  output logic                     int_valid,
  output logic                     fp_valid,
  output logic                     mem_valid,
  input  logic                     int_ready,
  input  logic                     fp_ready,
  input  logic                     mem_ready,
  output logic [XLEN-1:0]          int_instr,
  output logic [XLEN-1:0]          fp_instr,
  output logic [XLEN-1:0]          mem_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     stall
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]              perf_dispatched,
  output logic [31:0]              perf_stalls
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {CLS_INT = 2'd0, CLS_FP = 2'd1, CLS_MEM = 2'd2} cls_t;

  logic [XLEN-1:0] ifq [DEPTH];
  logic [AW:0]     wptr, rptr;
  logic [XLEN-1:0] head;
  logic            empty, full, push, pop;
  cls_t            tgt;
  logic [6:0]      opcode;
  logic [2:0]      slot_valid, slot_ready;
  logic [XLEN-1:0] slot_data [3];

  assign head       = ifq[rptr[AW-1:0]];
  assign opcode     = head[6:0];
  assign empty      = (wptr == rptr);
  assign full       = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign count      = wptr - rptr;
  assign in_ready   = !full;
  assign slot_ready = {mem_ready, fp_ready, int_ready};

  always_comb begin
    tgt = CLS_INT;
    if (opcode[6:5] == 2'b10)                tgt = CLS_FP;
    else if (!opcode[6] && !opcode[4])       tgt = CLS_MEM;
  end

  // A slot can take the head when empty or draining this cycle; no bypass past a blocked head.
  assign push  = in_valid && in_ready && !flush;
  assign pop   = !empty && (!slot_valid[tgt] || slot_ready[tgt]) && !flush;
  assign stall = !empty && slot_valid[tgt] && !slot_ready[tgt];

  always_ff @(posedge clk) begin
    if (push) ifq[wptr[AW-1:0]] <= in_instr;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_valid <= '0;
      for (int c = 0; c < 3; c++) slot_data[c] <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (flush) begin
          slot_valid[c] <= 1'b0;
        end else if (pop && (tgt == cls_t'(c))) begin
          slot_valid[c] <= 1'b1;
          slot_data[c]  <= head;
        end else if (slot_ready[c]) begin
          slot_valid[c] <= 1'b0;
        end
      end
    end
  end

  assign int_valid = slot_valid[0];
  assign fp_valid  = slot_valid[1];
  assign mem_valid = slot_valid[2];
  assign int_instr = slot_data[0];
  assign fp_instr  = slot_data[1];
  assign mem_instr = slot_data[2];

`ifdef DISPATCH_PERF_EN
  // Saturating; deliberately untouched by flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_dispatched <= '0;
      perf_stalls     <= '0;
    end else begin
      if (pop && (perf_dispatched != 32'hFFFF_FFFF))  perf_dispatched <= perf_dispatched + 32'd1;
      if (stall && (perf_stalls != 32'hFFFF_FFFF))    perf_stalls     <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_unit.sv
// tb/tb_dispatch_unit.sv - directed plus random checks of dispatch_unit against a queue model
module tb_dispatch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, flush;
  logic [31:0] in_instr;
  logic        int_valid, fp_valid, mem_valid;
  logic        int_ready, fp_ready, mem_ready;
  logic [31:0] int_instr, fp_instr, mem_instr;
  logic [3:0]  count;
  logic        stall;
`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_dispatched, perf_stalls;
`endif

  dispatch_unit #(.XLEN(32), .DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .flush(flush),
    .int_valid(int_valid), .fp_valid(fp_valid), .mem_valid(mem_valid),
    .int_ready(int_ready), .fp_ready(fp_ready), .mem_ready(mem_ready),
    .int_instr(int_instr), .fp_instr(fp_instr), .mem_instr(mem_instr),
    .count(count), .stall(stall)
`ifdef DISPATCH_PERF_EN
    , .perf_dispatched(perf_dispatched), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO contents plus one (valid, data) pair per issue class.
  logic [31:0] q[$];
  logic        sv [3];
  logic [31:0] sd [3];
  int          m_disp = 0;
  int          m_stalls = 0;

  function automatic int cls_of(input logic [31:0] ins);
    if (ins[6:5] == 2'b10) return 1;
    if (ins[6] == 1'b0 && ins[4] == 1'b0) return 2;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at negedge: apply inputs, check outputs, advance one edge, update model.
  task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic [2:0] r);
    int  t;
    logic e_stall, do_pop, do_push;
    logic [31:0] hd;
    in_valid = v; in_instr = ins; flush = fl;
    int_ready = r[0]; fp_ready = r[1]; mem_ready = r[2];
    #1;
    t  = (q.size() > 0) ? cls_of(q[0]) : 0;
    hd = (q.size() > 0) ? q[0] : 32'h0;
    e_stall = (q.size() > 0) && sv[t] && !r[t];
    chk("count", 64'(count), 64'(q.size()));
    chk("count_bound", 64'(count <= 4'd8), 64'd1);
    chk("in_ready", 64'(in_ready), 64'(q.size() != 8));
    chk("stall", 64'(stall), 64'(e_stall));
    chk("int_valid", 64'(int_valid), 64'(sv[0]));
    chk("fp_valid", 64'(fp_valid), 64'(sv[1]));
    chk("mem_valid", 64'(mem_valid), 64'(sv[2]));
    chk("int_instr", 64'(int_instr), 64'(sd[0]));
    chk("fp_instr", 64'(fp_instr), 64'(sd[1]));
    chk("mem_instr", 64'(mem_instr), 64'(sd[2]));
    @(posedge clk);
    if (e_stall) m_stalls++;
    if (fl) begin
      q.delete();
      for (int c = 0; c < 3; c++) sv[c] = 1'b0;
    end else begin
      do_pop  = (q.size() > 0) && (!sv[t] || r[t]);
      do_push = v && (q.size() != 8);
      for (int c = 0; c < 3; c++) begin
        if (do_pop && t == c) begin
          sv[c] = 1'b1;
          sd[c] = hd;
        end else if (r[c]) begin
          sv[c] = 1'b0;
        end
      end
      if (do_pop) begin
        void'(q.pop_front());
        m_disp++;
      end
      if (do_push) q.push_back(ins);
    end
    @(negedge clk);
  endtask

  logic [31:0] ops [8];

  initial begin
    ops[0] = 32'h33; ops[1] = 32'h53; ops[2] = 32'h03; ops[3] = 32'h13;
    ops[4] = 32'h27; ops[5] = 32'h07; ops[6] = 32'h63; ops[7] = 32'h73;
    for (int c = 0; c < 3; c++) begin
      sv[c] = 1'b0;
      sd[c] = 32'h0;
    end
    resetn = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
    int_ready = 1'b0; fp_ready = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_valids", 64'({int_valid, fp_valid, mem_valid}), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_data", 64'(int_instr | fp_instr | mem_instr), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // One instruction per class, back to back
    step(1, 32'h33, 0, 3'b111);
    step(1, 32'h53, 0, 3'b111);
    step(1, 32'h03, 0, 3'b111);
    repeat (4) step(0, 32'h0, 0, 3'b111);

    // Blocked FP slot only stalls an FP head
    step(1, 32'h53, 0, 3'b101);
    step(1, 32'h13, 0, 3'b101);
    step(1, 32'h153, 0, 3'b101);
    step(1, 32'h213, 0, 3'b101);
    step(0, 32'h0, 0, 3'b101);
    chk("fp_block_stall", 64'(stall), 64'd1);
    chk("fp_block_count", 64'(count), 64'd2);
    repeat (3) step(0, 32'h0, 0, 3'b101);
    repeat (5) step(0, 32'h0, 0, 3'b111);

    // Fill to full with all readies low, then a push refused alongside a pop
    for (int i = 0; i < 9; i++) step(1, 32'h1000 + 32'(i << 8) + 32'h13, 0, 3'b000);
    chk("full_count", 64'(count), 64'd8);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    step(1, 32'hBEEF0033, 0, 3'b001);
    chk("full_pop_count", 64'(count), 64'd7);
    repeat (10) step(0, 32'h0, 0, 3'b111);

    // Random traffic across pointer wrap
    for (int i = 0; i < 60; i++) begin
      logic [31:0] w;
      w = ($urandom & 32'hFFFF_FF80) | ops[$urandom_range(0, 7)];
      step(1'($urandom_range(0, 1)), w, 0, 3'($urandom_range(0, 7)));
    end
    repeat (12) step(0, 32'h0, 0, 3'b111);

    // Flush with five entries queued and two slots occupied
    step(1, 32'h00A00033, 0, 3'b000);
    step(1, 32'h00B00053, 0, 3'b000);
    for (int i = 0; i < 5; i++) step(1, 32'h00C00013 + 32'(i << 12), 0, 3'b000);
    chk("pre_flush_count", 64'(count), 64'd5);
    chk("pre_flush_valids", 64'({int_valid, fp_valid}), 64'd3);
    step(1, 32'hDEAD0013, 1, 3'b000);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valids", 64'({int_valid, fp_valid, mem_valid}), 64'd0);
    repeat (3) step(0, 32'h0, 0, 3'b111);

`ifdef DISPATCH_PERF_EN
    chk("perf_dispatched", 64'(perf_dispatched), 64'(m_disp));
    chk("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
    step(0, 32'h0, 1, 3'b111);
    chk("perf_disp_flush", 64'(perf_dispatched), 64'(m_disp));
    chk("perf_stalls_flush", 64'(perf_stalls), 64'(m_stalls));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dispatch_unit.md
# dispatch_unit

Parametrised in-order dispatch stage between instruction fetch and the integer, floating-point and memory issue queues. It buffers fetched instructions in a circular instruction fetch queue (IFQ) and decodes the head opcode into one of three classes. It forwards the head through a registered valid/ready output slot per class, one instruction per cycle. When the target slot cannot accept, it stalls in order, applying real backpressure that the previous dispatcher lacked.

## Interface
- XLEN, 32, instruction width; at least 7
- DEPTH, 8, IFQ entries; power of two, at least 2
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  IFQ can accept
- in_instr  in  XLEN  fetched instruction
- flush  in  1  synchronous pipeline flush
- int_valid / fp_valid / mem_valid  out  1  slot holds instruction for that issue queue
- int_ready / fp_ready / mem_ready  in  1  issue queue accepts slot contents
- int_instr / fp_instr / mem_instr  out  XLEN  slot contents
- count  out  $clog2(DEPTH)+1  IFQ occupancy
- stall  out  1  head valid but blocked this cycle
- perf_dispatched, perf_stalls  out  32 each  present only with DISPATCH_PERF_EN

## Operation
- IFQ storage: circular buffer, read and write pointers $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ.
- in_ready = (count != DEPTH), derived only from registered state. When full, a push is refused even if a pop happens in the same cycle.
- Push: in_valid && in_ready && !flush writes in_instr at the write pointer and advances it.
- Head class, from opcode = head[6:0]:
  - opcode[6:5]==2'b10 -> FP
  - else opcode[6]==0 && opcode[4]==0 -> MEM
  - else INT
- Each slot holds a valid bit and XLEN data. A slot can load when it is empty or its ready is high this cycle.
- Pop: IFQ non-empty, target slot can load, !flush. The head is copied into the target slot, that slot's valid is set, and the read pointer advances.
- A slot whose ready is high and that is not reloaded clears its valid.
- Strictly in order: a blocked head blocks all younger entries, with no bypass. At most one pop per cycle.
- stall = IFQ non-empty && target slot valid && target ready low (combinational).
- Simultaneous push and pop: count is unchanged, both pointers advance.
- flush has top priority:
  - pointers, count and all slot valids clear at the edge
  - any push and pop that cycle are discarded
  - slot data registers are not cleared
- Reset (asynchronous): pointers and count are 0. All valid outputs and stall are 0. in_ready is 1. All *_instr outputs are 0. Perf counters are 0.
- Pointer wrap: pointers increment modulo 2*DEPTH. No other special case.

## Timing
- Latency is 2 edges from accept to slot valid. An instruction accepted at edge E0 is at the head after E0, moves into its slot at E1, and *_valid is seen high after E1.
- Sustained throughput is 1 instruction per cycle when all readies are held high.
- Slot handoff completes at the edge where valid && ready. Back-to-back transfers into the same slot occur without bubbles.
- stall and in_ready carry no combinational path from in_valid. stall depends combinationally on *_ready.

## Configuration
- DISPATCH_PERF_EN defined:
  - perf_dispatched increments on every pop.
  - perf_stalls increments every cycle stall is 1.
  - Both are 32-bit, saturate at 0xFFFFFFFF, are cleared only by resetn, and are unaffected by flush.
- DISPATCH_PERF_EN undefined: both ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then push INT 0x00000033, FP 0x00000053, MEM 0x00000003 on consecutive cycles with all readies 1. Expect int_valid, fp_valid, mem_valid each high for exactly one cycle, on the 2nd, 3rd and 4th cycles after the first push, with matching data.
- Hold fp_ready 0 and push FP 0x00000053, then INT 0x00000013. After the FP enters its slot, the INT fills nothing: stall is 0 while the FP slot is occupied, and the INT dispatches, since a blocked slot only stalls a head targeting it. Then push a second FP. Expect stall=1 and the INT behind it held until fp_ready rises.
- Push 8 entries with DEPTH=8 and all readies 0. Expect count=8 and in_ready=0. Assert in_valid with int_ready 1 in the same cycle. Expect no push and count=7.
- Run 20 pushes and pops through DEPTH=8 with random readies. Expect output order identical to input order across pointer wrap, and count to never exceed 8.
- Pre-load 5 entries and 2 slots, then pulse flush together with in_valid=1. Expect count=0, all slot valids 0 next cycle, and the pushed word dropped.
- With DISPATCH_PERF_EN, after 3 dispatches and 4 stall cycles, expect perf_dispatched=3 and perf_stalls=4. Flush must leave both unchanged.
